// File: rtl/gpu_fill_engine_if.sv
// Bus bundle between the fill engine, the GPU register bank (command side)
// and the SDRAM controller write port (burst side).
interface gpu_fill_engine_if;
  // Command side from the register bank
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [23:0] pixel;
  logic [23:0] len;
  logic        enable;
  logic        ping_pong;
  logic        busy;
  logic        done;
  logic        err;

  // Burst side towards the SDRAM controller
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [8:0]  wr_len;
  logic        wr_ack;
  logic        wr_data_req;
  logic [23:0] wr_data;

  // The fill engine drives status and burst requests
  modport master (
    input  x_pos, y_pos, pixel, len, enable, ping_pong,
    output busy, done, err,
    output wr_req, wr_addr, wr_len, wr_data,
    input  wr_ack, wr_data_req
  );

  // Register bank plus SDRAM controller, seen from the other side
  modport slave (
    output x_pos, y_pos, pixel, len, enable, ping_pong,
    input  busy, done, err,
    input  wr_req, wr_addr, wr_len, wr_data,
    output wr_ack, wr_data_req
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// Span-fill engine: turns one fill command (start X/Y, colour, pixel count)
// into page-safe SDRAM write bursts into the selected ping-pong framebuffer.
// Spans running past the end of the framebuffer are clipped and flagged.
module gpu_fill_engine #(
  parameter int          H_RES     = 1024,
  parameter int          V_RES     = 768,
  parameter int          MAX_BURST = 256,
  parameter logic [23:0] PONG_BASE = 24'h100000
) (
  input  logic              clk,
  input  logic              rst,
  gpu_fill_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  // Framebuffer size in words, kept at 25 bits for the clip compare
  localparam logic [24:0] FB_WORDS   = 25'(H_RES * V_RES);
  localparam logic [23:0] FB_WORDS_W = 24'(H_RES * V_RES);
  localparam logic [23:0] PAGE_WORDS = 24'(MAX_BURST);
  localparam logic [23:0] PAGE_MASK  = 24'(MAX_BURST - 1);
  localparam logic [23:0] H_RES_W    = 24'(H_RES);
  localparam logic [31:0] H_LIMIT    = 32'(H_RES);
  localparam logic [31:0] V_LIMIT    = 32'(V_RES);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_armed;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [23:0] r_len;
  logic        r_pp;
  logic [23:0] r_color;
  logic [23:0] r_addr;
  logic [23:0] r_rem;
  logic [8:0]  r_cur_len;
  logic [8:0]  r_cnt;
  logic        r_err;

  logic [23:0] w_offset;
  logic [24:0] w_end;
  logic        w_out_of_range;
  logic        w_clip;
  logic [23:0] w_base;
  logic [23:0] w_room;
  logic [8:0]  w_burst;
  logic        w_last_word;
  logic [23:0] w_rem_after;
  logic        w_accept;

  // Linear pixel offset of the span start; wraps at 24 bits like the bus
  assign w_offset       = 24'(r_y) * H_RES_W + 24'(r_x);
  assign w_end          = {1'b0, w_offset} + {1'b0, r_len};
  assign w_out_of_range = ({16'd0, r_x} >= H_LIMIT) || ({16'd0, r_y} >= V_LIMIT);
  assign w_clip         = (w_end > FB_WORDS);
  assign w_base         = r_pp ? PONG_BASE : 24'd0;

  // Words left before the next page boundary, then the burst actually issued
  assign w_room      = PAGE_WORDS - (r_addr & PAGE_MASK);
  assign w_burst     = (r_rem < w_room) ? r_rem[8:0] : w_room[8:0];

  assign w_last_word = bus.wr_data_req && (r_cnt == (r_cur_len - 9'd1));
  assign w_rem_after = r_rem - {15'd0, r_cur_len};
  assign w_accept    = (r_state == S_IDLE) && bus.enable && r_armed;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_len  = 9'd0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        bus.busy = 1'b1;
        if (w_out_of_range || (r_len == 24'd0)) w_state_nxt = S_DONE;
        else                                     w_state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.busy   = 1'b1;
        bus.wr_req = 1'b1;
        bus.wr_len = w_burst;
        if (bus.wr_ack) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        bus.busy = 1'b1;
        if (w_last_word) begin
          w_state_nxt = (w_rem_after != 24'd0) ? S_REQ : S_DONE;
        end
      end
      S_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Re-arm on enable low in IDLE so a held enable cannot retrigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_accept)         r_armed <= 1'b0;
      else if (!bus.enable) r_armed <= 1'b1;
    end
  end

  // Command latch on acceptance; colour holds for the whole operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_len   <= 24'd0;
      r_pp    <= 1'b0;
      r_color <= 24'd0;
    end else if (w_accept) begin
      r_x     <= bus.x_pos;
      r_y     <= bus.y_pos;
      r_len   <= bus.len;
      r_pp    <= bus.ping_pong;
      r_color <= bus.pixel;
    end
  end

  // Error flag: cleared by a new command, set by range reject or clip
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == S_SETUP) begin
      if (w_out_of_range)                 r_err <= 1'b1;
      else if ((r_len != 24'd0) && w_clip) r_err <= 1'b1;
    end
  end

  // Address / remaining-count / per-burst word counter datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= 24'd0;
      r_rem     <= 24'd0;
      r_cur_len <= 9'd0;
      r_cnt     <= 9'd0;
    end else begin
      unique case (r_state)
        S_SETUP: begin
          r_addr <= w_base + w_offset;
          r_rem  <= w_clip ? (FB_WORDS_W - w_offset) : r_len;
        end
        S_REQ: begin
          if (bus.wr_ack) begin
            r_cur_len <= w_burst;
            r_cnt     <= 9'd0;
          end
        end
        S_DATA: begin
          if (w_last_word) begin
            r_addr <= r_addr + {15'd0, r_cur_len};
            r_rem  <= w_rem_after;
            r_cnt  <= 9'd0;
          end else if (bus.wr_data_req) begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.err     = r_err;
  assign bus.wr_addr = r_addr;
  assign bus.wr_data = r_color;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Testbench for gpu_fill_engine: table of directed fill commands with
// hand-computed burst layouts, plus sequences for ack delay, gapped data,
// held enable and reset in the middle of a burst.
module tb_gpu_fill_engine;

  localparam int CYC_LIMIT = 4000;

  logic clk;
  logic rst;

  gpu_fill_engine_if bus ();

  gpu_fill_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] len;
    logic        pp;
    logic [23:0] col;
    int          nb;     // expected burst count
    logic [23:0] a0;     // first burst address
    int          l0;     // first burst length
    logic [23:0] al;     // last burst address
    int          ll;     // last burst length
    int          words;  // total data words
    logic        err;
  } vec_t;

  vec_t vt [10];

  int errors = 0;
  int checks = 0;

  // Results gathered by run_cmd
  logic [23:0] b_addr [$];
  int          b_len  [$];
  int          word_cnt;
  int          data_bad;
  int          unstable;
  int          ack_drop_bad;
  int          first_busy;
  int          first_req;
  int          done_cnt;
  logic        busy_after;
  logic        timed_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command and act as the SDRAM controller until done (+1 cycle).
  // Called and returns just after a falling edge.
  task automatic run_cmd(input logic [15:0] x, input logic [15:0] y, input logic [23:0] len,
                         input logic pp, input logic [23:0] col, input int ack_dly,
                         input bit gaps, input bit hold_en, input int abort_at);
    int          wait_cnt;
    int          words_left;
    int          done_cyc;
    bit          req_seen;
    bit          fin;
    bit          aborted;
    logic [23:0] h_addr;
    logic [8:0]  h_len;

    b_addr.delete();
    b_len.delete();
    word_cnt = 0; data_bad = 0; unstable = 0; ack_drop_bad = 0;
    first_busy = -1; first_req = -1; done_cnt = 0; busy_after = 1'bx; timed_out = 1'b0;
    wait_cnt = 0; words_left = 0; done_cyc = -1; req_seen = 0; fin = 0; aborted = 0;
    h_addr = '0; h_len = '0;

    bus.x_pos = x; bus.y_pos = y; bus.len = len; bus.ping_pong = pp; bus.pixel = col;
    bus.enable = 1'b1;

    for (int cyc = 1; cyc <= CYC_LIMIT && !fin && !aborted; cyc++) begin
      @(negedge clk);
      if (bus.busy && first_busy < 0) first_busy = cyc;
      if (bus.busy && !hold_en) bus.enable = 1'b0;
      if (bus.wr_req && first_req < 0) first_req = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = bus.busy;
        fin = 1;
      end

      // Burst request / acknowledge
      if (bus.wr_ack) begin
        if (bus.wr_req) ack_drop_bad++;
        bus.wr_ack = 1'b0;
      end else if (bus.wr_req) begin
        if (!req_seen) begin
          req_seen = 1; h_addr = bus.wr_addr; h_len = bus.wr_len; wait_cnt = 0;
        end else if (bus.wr_addr !== h_addr || bus.wr_len !== h_len) begin
          unstable++;
        end
        if (wait_cnt >= ack_dly) begin
          bus.wr_ack = 1'b1;
          b_addr.push_back(bus.wr_addr);
          b_len.push_back(int'(bus.wr_len));
          words_left = int'(bus.wr_len);
          req_seen = 0;
        end else begin
          wait_cnt++;
        end
      end

      // Data pull
      bus.wr_data_req = 1'b0;
      if (!bus.wr_ack && words_left > 0) begin
        if (!gaps || (cyc % 3 != 0)) begin
          bus.wr_data_req = 1'b1;
          words_left--;
          word_cnt++;
          if (bus.wr_data !== col) data_bad++;
        end
      end

      if (abort_at > 0 && word_cnt >= abort_at) aborted = 1;
    end
    if (!fin && !aborted) timed_out = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},    32'(bus.busy),    32'd0);
    check({tag, ".done"},    32'(bus.done),    32'd0);
    check({tag, ".err"},     32'(bus.err),     32'd0);
    check({tag, ".wr_req"},  32'(bus.wr_req),  32'd0);
    check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, ".wr_len"},  32'(bus.wr_len),  32'd0);
    check({tag, ".wr_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  initial begin
    int busy_cnt;

    //        x       y       len        pp    colour       nb a0          l0   al          ll   words err
    vt[0] = '{16'd3,    16'd2,   24'd1,    1'b0, 24'hFF0000, 1, 24'd2051,    1, 24'd2051,    1,   1,   1'b0};
    vt[1] = '{16'd0,    16'd0,   24'd1024, 1'b0, 24'h00FF00, 4, 24'd0,     256, 24'd768,   256, 1024, 1'b0};
    vt[2] = '{16'd250,  16'd0,   24'd10,   1'b1, 24'h0000FF, 2, 24'h1000FA,  6, 24'h100100,  4,  10, 1'b0};
    vt[3] = '{16'd1024, 16'd0,   24'd5,    1'b0, 24'h123456, 0, 24'd0,       0, 24'd0,       0,   0, 1'b1};
    vt[4] = '{16'd1023, 16'd767, 24'd5,    1'b0, 24'hABCDEF, 1, 24'd786431,  1, 24'd786431,  1,   1, 1'b1};
    vt[5] = '{16'd5,    16'd5,   24'd0,    1'b0, 24'h111111, 0, 24'd0,       0, 24'd0,       0,   0, 1'b0};
    vt[6] = '{16'd0,    16'd768, 24'd3,    1'b1, 24'h222222, 0, 24'd0,       0, 24'd0,       0,   0, 1'b1};
    vt[7] = '{16'd0,    16'd1,   24'd300,  1'b1, 24'h333333, 2, 24'h100400,256, 24'h100500, 44, 300, 1'b0};
    vt[8] = '{16'd1000, 16'd767, 24'd100,  1'b1, 24'h444444, 1, 24'h1BFFE8, 24, 24'h1BFFE8, 24,  24, 1'b1};
    vt[9] = '{16'd255,  16'd0,   24'd2,    1'b0, 24'h555555, 2, 24'd255,     1, 24'd256,     1,   2, 1'b0};

    bus.x_pos = '0; bus.y_pos = '0; bus.len = '0; bus.pixel = '0;
    bus.enable = 1'b0; bus.ping_pong = 1'b0; bus.wr_ack = 1'b0; bus.wr_data_req = 1'b0;

    // Reset state
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven commands, prompt ack and continuous data
    for (int i = 0; i < 10; i++) begin
      run_cmd(vt[i].x, vt[i].y, vt[i].len, vt[i].pp, vt[i].col, 0, 1'b0, 1'b0, 0);
      check($sformatf("v%0d.timeout", i), 32'(timed_out), 32'd0);
      check($sformatf("v%0d.bursts", i), 32'(b_addr.size()), 32'(vt[i].nb));
      if (vt[i].nb > 0 && b_addr.size() > 0) begin
        check($sformatf("v%0d.addr0", i), 32'(b_addr[0]), 32'(vt[i].a0));
        check($sformatf("v%0d.len0", i), 32'(b_len[0]), 32'(vt[i].l0));
        check($sformatf("v%0d.addrN", i), 32'(b_addr[b_addr.size()-1]), 32'(vt[i].al));
        check($sformatf("v%0d.lenN", i), 32'(b_len[b_len.size()-1]), 32'(vt[i].ll));
      end
      check($sformatf("v%0d.words", i), 32'(word_cnt), 32'(vt[i].words));
      check($sformatf("v%0d.data", i), 32'(data_bad), 32'd0);
      check($sformatf("v%0d.err", i), 32'(bus.err), 32'(vt[i].err));
      check($sformatf("v%0d.done", i), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d.busy_after", i), 32'(busy_after), 32'd0);
      check($sformatf("v%0d.ack_drop", i), 32'(ack_drop_bad), 32'd0);
      if (i == 0) begin
        check("v0.busy_cycle", 32'(first_busy), 32'd1);
        check("v0.req_cycle", 32'(first_req), 32'd2);
      end
      @(negedge clk);
    end

    // Delayed ack with gapped data: 3172 -> (3172,156) (3328,256) (3584,188)
    run_cmd(16'd100, 16'd3, 24'd600, 1'b0, 24'h0F0F0F, 5, 1'b1, 1'b0, 0);
    check("slow.timeout", 32'(timed_out), 32'd0);
    check("slow.bursts", 32'(b_addr.size()), 32'd3);
    if (b_addr.size() == 3) begin
      check("slow.addr0", 32'(b_addr[0]), 32'd3172);
      check("slow.len0",  32'(b_len[0]),  32'd156);
      check("slow.addr1", 32'(b_addr[1]), 32'd3328);
      check("slow.len1",  32'(b_len[1]),  32'd256);
      check("slow.addr2", 32'(b_addr[2]), 32'd3584);
      check("slow.len2",  32'(b_len[2]),  32'd188);
    end
    check("slow.stable", 32'(unstable), 32'd0);
    check("slow.words", 32'(word_cnt), 32'd600);
    check("slow.data", 32'(data_bad), 32'd0);
    check("slow.err", 32'(bus.err), 32'd0);
    @(negedge clk);

    // Enable held high after done: no retrigger until it drops
    run_cmd(16'd3, 16'd2, 24'd1, 1'b0, 24'hFF0000, 0, 1'b0, 1'b1, 0);
    check("hold.done", 32'(done_cnt), 32'd1);
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.busy || bus.wr_req) busy_cnt++;
    end
    check("hold.no_retrigger", 32'(busy_cnt), 32'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    run_cmd(16'd7, 16'd0, 24'd2, 1'b0, 24'h777777, 0, 1'b0, 1'b0, 0);
    check("rearm.done", 32'(done_cnt), 32'd1);
    check("rearm.bursts", 32'(b_addr.size()), 32'd1);
    if (b_addr.size() > 0) check("rearm.addr0", 32'(b_addr[0]), 32'd7);
    @(negedge clk);

    // Reset in the middle of a data phase, then a normal command
    run_cmd(16'd0, 16'd0, 24'd1024, 1'b1, 24'hCAFE00, 0, 1'b0, 1'b0, 20);
    check("mid.in_data", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.wr_ack = 1'b0; bus.wr_data_req = 1'b0; bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(16'd3, 16'd2, 24'd1, 1'b0, 24'hFF0000, 0, 1'b0, 1'b0, 0);
    check("post.timeout", 32'(timed_out), 32'd0);
    check("post.bursts", 32'(b_addr.size()), 32'd1);
    if (b_addr.size() > 0) begin
      check("post.addr0", 32'(b_addr[0]), 32'd2051);
      check("post.len0", 32'(b_len[0]), 32'd1);
    end
    check("post.words", 32'(word_cnt), 32'd1);
    check("post.done", 32'(done_cnt), 32'd1);
    check("post.err", 32'(bus.err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
